// File: rtl/sound_ctrl_latch_if.sv
// CPU write bus as seen by the sound control latch.
// The CPU side drives address, strobe and data, and the latch only samples them.
interface sound_ctrl_latch_if;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_data;

  modport master (output cpu_addr, output cpu_wr, output cpu_data);
  modport slave  (input  cpu_addr, input  cpu_wr, input  cpu_data);
endinterface

// File: rtl/sound_ctrl_latch.sv
// Sound control latch. It decodes CPU writes to the control and crash
// registers and holds the levels that the analog sound mixer reads.
// A 0->1 write on the shell or explosion trigger is stretched to a minimum
// number of 12 kHz ticks. A watchdog mutes everything if the CPU stops
// refreshing the control register.
module sound_ctrl_latch #(
  parameter logic [15:0] CTRL_ADDR     = 16'h1840,
  parameter logic [15:0] CRSH_ADDR     = 16'h1808,
  parameter int          STRETCH_TICKS = 4,
  parameter int          MUTE_TICKS    = 12000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_12KHz_en,
  input  logic                 mod_redbaron,
  sound_ctrl_latch_if.slave    bus,
  output logic                 sound_enable,
  output logic                 motor_en,
  output logic                 engine_rev_en,
  output logic                 shell_ls,
  output logic                 shell_en,
  output logic                 explo_ls,
  output logic                 explo_en,
  output logic [3:0]           crsh,
  output logic                 muted
);

  localparam logic [2:0]  STRETCH_LOAD = 3'(STRETCH_TICKS);
  localparam logic [13:0] MUTE_LIMIT   = 14'(MUTE_TICKS);

  // Control register without D6, which has no meaning to the mixer.
  // Bit order is {D7, D5, D4, D3, D2, D1, D0}.
  logic [6:0]  ctrl_reg;
  logic [3:0]  crsh_reg;
  logic        wr_prev_reg;
  logic [13:0] wd_cnt_reg;
  logic        muted_reg;

  // Stretch channels: index 0 is explosion (D1), index 1 is shell (D3).
  logic [2:0]  stretch_cnt_reg [2];
  logic [1:0]  stretch_arm;
  logic [1:0]  stretch_active;

  logic        wr_rise;
  logic        ctrl_wr;
  logic        crsh_wr;
  logic        wd_expire;
  logic        d6_unused;

  assign d6_unused = bus.cpu_data[6];

  // Decode a write once per strobe: only the rising edge of cpu_wr counts.
  always_comb begin
    wr_rise        = bus.cpu_wr & ~wr_prev_reg;
    ctrl_wr        = wr_rise && (bus.cpu_addr == CTRL_ADDR);
    crsh_wr        = wr_rise && (bus.cpu_addr == CRSH_ADDR) && mod_redbaron;
    stretch_arm[0] = ctrl_wr && bus.cpu_data[1] && !ctrl_reg[1];
    stretch_arm[1] = ctrl_wr && bus.cpu_data[3] && !ctrl_reg[3];
    // A control write in the same clock as a tick wins, so the limit is not reached.
    wd_expire      = clk_12KHz_en && !ctrl_wr && (wd_cnt_reg == MUTE_LIMIT - 14'd1);
  end

  // Remember the previous strobe level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_prev_reg <= 1'b0;
    else        wr_prev_reg <= bus.cpu_wr;
  end

  // Control register: loaded by a CTRL write, wiped once the watchdog has muted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ctrl_reg <= '0;
    else if (ctrl_wr)   ctrl_reg <= {bus.cpu_data[7], bus.cpu_data[5:0]};
    else if (muted_reg) ctrl_reg <= '0;
  end

  // Crash nibble exists only on Red Baron; leaving that mode or muting clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         crsh_reg <= '0;
    else if (!mod_redbaron || muted_reg) crsh_reg <= '0;
    else if (crsh_wr)                   crsh_reg <= bus.cpu_data[3:0];
  end

  // Per-channel stretch counter. It is (re)armed by a 0->1 trigger write
  // and runs down on 12 kHz ticks. A 1->0 write leaves a running count alone.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stretch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stretch_cnt_reg[gi] <= '0;
      else if (stretch_arm[gi])
        stretch_cnt_reg[gi] <= STRETCH_LOAD;
      else if (muted_reg)
        stretch_cnt_reg[gi] <= '0;
      else if (clk_12KHz_en && (stretch_cnt_reg[gi] != 3'd0))
        stretch_cnt_reg[gi] <= stretch_cnt_reg[gi] - 3'd1;
    end
    assign stretch_active[gi] = (stretch_cnt_reg[gi] != 3'd0);
  end

  // Watchdog tick counter: CTRL writes reset it, and it saturates at the mute limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_cnt_reg <= '0;
    else if (ctrl_wr)
      wd_cnt_reg <= '0;
    else if (clk_12KHz_en && (wd_cnt_reg != MUTE_LIMIT))
      wd_cnt_reg <= wd_cnt_reg + 14'd1;
  end

  // Mute flag: set when the watchdog reaches its limit and held until a CTRL write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         muted_reg <= 1'b0;
    else if (ctrl_wr)   muted_reg <= 1'b0;
    else if (wd_expire) muted_reg <= 1'b1;
  end

  // Outputs come only from registers. Muting forces them low at once,
  // and the register clear that follows keeps them low.
  always_comb begin
    motor_en      = ~muted_reg & ctrl_reg[6];
    sound_enable  = ~muted_reg & ctrl_reg[5];
    engine_rev_en = ~muted_reg & ctrl_reg[4];
    shell_en      = ~muted_reg & (ctrl_reg[3] | stretch_active[1]);
    shell_ls      = ~muted_reg & ctrl_reg[2];
    explo_en      = ~muted_reg & (ctrl_reg[1] | stretch_active[0]);
    explo_ls      = ~muted_reg & ctrl_reg[0];
    crsh          = muted_reg ? 4'h0 : crsh_reg;
    muted         = muted_reg;
  end

endmodule

// File: tb/tb_sound_ctrl_latch.sv
// Scoreboard bench for sound_ctrl_latch. Each step queues the output vector it
// expects, and the queue is drained against the DUT once the step's clocks have run.
// Vector layout: {muted, crsh[3:0], D7, 0, D5, D4, shell_en, D2, explo_en, D0}.
module tb_sound_ctrl_latch;

  localparam logic [15:0] CTRL = 16'h1840;
  localparam logic [15:0] CRSH = 16'h1808;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_12KHz_en = 1'b0;
  logic       mod_redbaron = 1'b0;
  logic       sound_enable, motor_en, engine_rev_en, shell_ls, shell_en;
  logic       explo_ls, explo_en, muted;
  logic [3:0] crsh;

  sound_ctrl_latch_if bus ();

  sound_ctrl_latch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_12KHz_en  (clk_12KHz_en),
    .mod_redbaron  (mod_redbaron),
    .bus           (bus),
    .sound_enable  (sound_enable),
    .motor_en      (motor_en),
    .engine_rev_en (engine_rev_en),
    .shell_ls      (shell_ls),
    .shell_en      (shell_en),
    .explo_ls      (explo_ls),
    .explo_en      (explo_en),
    .crsh          (crsh),
    .muted         (muted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [12:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [12:0] obs_vec();
    return {muted, crsh, motor_en, 1'b0, sound_enable, engine_rev_en,
            shell_en, shell_ls, explo_en, explo_ls};
  endfunction

  task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_vec(input string tag, input logic [12:0] vec);
    exp_t e;
    e.tag = tag;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs_vec(), e.vec);
    end
  endtask

  // One CPU write with the strobe held for 'hold' clocks. It can optionally
  // tick the 12 kHz enable on the accepting clock, and it returns on a negedge.
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data,
                           input int hold, input logic with_tick);
    @(negedge clk);
    bus.cpu_addr = addr;
    bus.cpu_data = data;
    bus.cpu_wr   = 1'b1;
    clk_12KHz_en = with_tick;
    @(negedge clk);
    clk_12KHz_en = 1'b0;
    repeat (hold - 1) @(negedge clk);
    bus.cpu_wr = 1'b0;
    $display("txn write addr=%h data=%h hold=%0d tick=%0b", addr, data, hold, with_tick);
  endtask

  // Hold the tick enable high for n consecutive clocks.
  task automatic ticks(input int n);
    @(negedge clk);
    clk_12KHz_en = 1'b1;
    repeat (n) @(negedge clk);
    clk_12KHz_en = 1'b0;
  endtask

  initial begin
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    bus.cpu_wr   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    expect_vec("reset_held", 13'h000);
    drain();
    rst_n = 1'b1;
    @(negedge clk);
    expect_vec("reset_released", 13'h000);
    drain();

    // CTRL A0: outputs must not move before the accepting edge
    @(negedge clk);
    bus.cpu_addr = CTRL;
    bus.cpu_data = 8'hA0;
    bus.cpu_wr   = 1'b1;
    #1;
    expect_vec("a0_before_edge", 13'h000);
    drain();
    @(negedge clk);
    bus.cpu_wr = 1'b0;
    expect_vec("a0_after_edge", 13'h0A0);
    drain();
    $display("txn write addr=%h data=a0 hold=1 tick=0", CTRL);

    // Shell stretch: 08 then 00 holds shell_en for exactly 4 ticks
    cpu_write(CTRL, 8'h08, 1, 1'b0);
    expect_vec("shell_set", 13'h008);
    drain();
    cpu_write(CTRL, 8'h00, 1, 1'b0);
    expect_vec("shell_cleared_stretch", 13'h008);
    drain();
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      expect_vec($sformatf("shell_tick%0d", i + 1), 13'h008);
      drain();
    end
    ticks(1);
    expect_vec("shell_tick4_end", 13'h000);
    drain();

    // Held strobe is one write: explo armed once, two ticks consumed while held
    @(negedge clk);
    bus.cpu_addr = CTRL;
    bus.cpu_data = 8'h02;
    bus.cpu_wr   = 1'b1;
    @(negedge clk);
    clk_12KHz_en = 1'b1;
    repeat (2) @(negedge clk);
    clk_12KHz_en = 1'b0;
    repeat (2) @(negedge clk);
    bus.cpu_wr = 1'b0;
    $display("txn write addr=%h data=02 hold=5 tick=2", CTRL);
    expect_vec("explo_held", 13'h002);
    drain();
    cpu_write(CTRL, 8'h00, 1, 1'b0);
    expect_vec("explo_remaining2", 13'h002);
    drain();
    ticks(1);
    expect_vec("explo_remaining1", 13'h002);
    drain();
    ticks(1);
    expect_vec("explo_done", 13'h000);
    drain();

    // Crash register gating by mod_redbaron
    mod_redbaron = 1'b1;
    cpu_write(CRSH, 8'hF5, 1, 1'b0);
    expect_vec("crsh_write", 13'h500);
    drain();
    @(negedge clk);
    mod_redbaron = 1'b0;
    @(negedge clk);
    expect_vec("crsh_mode_drop", 13'h000);
    drain();
    cpu_write(CRSH, 8'h07, 1, 1'b0);
    expect_vec("crsh_ignored", 13'h000);
    drain();

    // Watchdog mute
    mod_redbaron = 1'b1;
    cpu_write(CRSH, 8'h03, 1, 1'b0);
    cpu_write(CTRL, 8'hBF, 1, 1'b0);
    expect_vec("bf_set", 13'h3BF);
    drain();
    ticks(11999);
    expect_vec("wd_11999", 13'h3BF);
    drain();
    ticks(1);
    expect_vec("wd_muted", 13'h1000);
    drain();
    repeat (2) @(negedge clk);
    expect_vec("wd_muted_hold", 13'h1000);
    drain();
    cpu_write(CRSH, 8'h09, 1, 1'b0);
    expect_vec("crsh_while_muted", 13'h1000);
    drain();
    // Write together with a tick: the write wins and the counter restarts from 0
    cpu_write(CTRL, 8'h20, 1, 1'b1);
    expect_vec("unmute", 13'h020);
    drain();
    ticks(11999);
    expect_vec("wd2_11999", 13'h020);
    drain();
    ticks(1);
    expect_vec("wd2_muted", 13'h1000);
    drain();
    mod_redbaron = 1'b0;

    // Asynchronous reset during a running stretch
    cpu_write(CTRL, 8'h88, 1, 1'b0);
    expect_vec("rst_pre_set", 13'h088);
    drain();
    cpu_write(CTRL, 8'h80, 1, 1'b0);
    ticks(1);
    expect_vec("rst_pre_stretch", 13'h088);
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_vec("rst_async", 13'h000);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    ticks(5);
    expect_vec("rst_no_resume", 13'h000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
